// File: rtl/uart_pkg.sv
// Shared constants and helpers for the parametrised UART receiver.
// No logic here, so no latency.
// No flow control here; the receiver and its FIFO handle backpressure.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE      = 3'd0;
    localparam rx_state_t ST_START     = 3'd1;
    localparam rx_state_t ST_DATA      = 3'd2;
    localparam rx_state_t ST_PARITY    = 3'd3;
    localparam rx_state_t ST_STOP      = 3'd4;
    localparam rx_state_t ST_WAIT_IDLE = 3'd5;

    // Clock cycles per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = (clk_freq + (baud * oversample) / 2) / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with head word shown combinationally.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, oversample tick, majority-vote FSM, receive FIFO.
// Latency: rx_valid rises one cycle after the decision at mid-point of the last stop bit.
// Backpressure: rx_valid/rx_ready pop; a good frame arriving while the FIFO is full is dropped and sets overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [IW-1:0] S_LO      = IW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] S_MID     = IW'(OVERSAMPLE / 2);
    localparam logic [IW-1:0] S_HI      = IW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rx_meta, rx_s, rx_q;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    rx_state_t            state;
    logic [IW-1:0]        idx;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [1:0]           smp;
    logic                 maj, at_mid, at_end, start_edge, decide;
    logic                 frame_bad, par_bad;
    logic                 push_vld, pop_vld, fifo_full, fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign start_edge = (state == ST_IDLE) && rx_q && !rx_s;
    assign tick       = (div_cnt == DIV_LAST);

    // Restarting the divider on the start edge phase-aligns every tick to the frame.
    always_ff @(posedge clk) begin
        if (reset || start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign maj       = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign at_mid    = tick && (idx == S_HI);
    assign at_end    = tick && (idx == IDX_LAST);
    assign decide    = (state == ST_STOP) && at_mid && (stop_cnt == STOP_LAST);
    assign frame_bad = stop_bad | ~maj;
    assign par_bad   = (PARITY != PAR_NONE) && ((^shreg ^ par_bit) != 1'(PARITY == PAR_ODD));
    assign push_vld  = decide && !frame_bad && !par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            stop_bad   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            smp        <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= decide && frame_bad;
            parity_err <= decide && par_bad;
            if (tick) begin
                if (idx == S_LO)  smp[0] <= rx_s;
                if (idx == S_MID) smp[1] <= rx_s;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state <= ST_START;
                        idx   <= '0;
                    end
                end
                ST_START: begin
                    if (at_mid && maj) begin
                        state <= ST_IDLE;
                    end else if (at_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (at_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            stop_cnt <= 1'b0;
                            stop_bad <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_mid) par_bit <= maj;
                    if (at_end) begin
                        state    <= ST_STOP;
                        stop_cnt <= 1'b0;
                        stop_bad <= 1'b0;
                    end
                end
                ST_STOP: begin
                    // Leave right after the last stop decision so a back-to-back start edge is not missed.
                    if (at_mid) begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= frame_bad ? ST_WAIT_IDLE : ST_IDLE;
                        end else begin
                            stop_bad <= stop_bad | ~maj;
                        end
                    end else if (at_end) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop_vld  = rx_valid && rx_ready;
    assign rx_valid = !fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_vld),
        .push_dat (shreg),
        .pop      (pop_vld),
        .pop_dat  (rx_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A fresh overrun outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push_vld && fifo_full && !pop_vld) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
